// File: rtl/mbus_def_pkg.sv
// Shared definitions for the MBus TX sequencer slice.
// State encoding and parameter defaults.
package mbus_def;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_FILL,
    ST_SEND,
    ST_REQ,
    ST_RELEASE,
    ST_RESP,
    ST_RESPACK,
    ST_DRAIN
  } state_e;

  localparam logic [15:0] ACK_TIMEOUT_DEF = 16'hFFFF;
  localparam int ADDR_WIDTH_DEF = 32;
  localparam int DATA_WIDTH_DEF = 32;
  localparam int DEPTH_DEF = 8;

endpackage

// File: rtl/mbus_tx_sequencer_word_buf.sv
// One-message word store: write port, combinational read port,
// fill and last-word tracking.
module mbus_tx_word_buf
  import mbus_def::*;
#(
  parameter int DATA_WIDTH = DATA_WIDTH_DEF,
  parameter int DEPTH      = DEPTH_DEF
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  wr_en_i,
  input  logic                  wr_first_i,
  input  logic [DATA_WIDTH-1:0] wr_data_i,
  input  logic                  rd_inc_i,
  output logic [DATA_WIDTH-1:0] rd_data_o,
  output logic                  full_o,
  output logic                  rd_last_o
);

  localparam int PW = $clog2(DEPTH);

  logic [DATA_WIDTH-1:0] mem_q [DEPTH];
  logic [PW-1:0]         wptr_q;
  logic [PW-1:0]         rptr_q;
  logic [PW-1:0]         lidx_q;
  logic [PW-1:0]         waddr;

  // A first word always lands at slot 0, whatever the old fill level.
  assign waddr     = wr_first_i ? '0 : wptr_q;
  assign full_o    = (waddr == PW'(DEPTH - 1));
  assign rd_data_o = mem_q[rptr_q];
  assign rd_last_o = (rptr_q == lidx_q);

  always_ff @(posedge clk_i) begin
    if (wr_en_i) begin
      mem_q[waddr] <= wr_data_i;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wptr_q <= '0;
      rptr_q <= '0;
      lidx_q <= '0;
    end else begin
      if (wr_en_i) begin
        lidx_q <= waddr;
        wptr_q <= full_o ? waddr : waddr + 1'b1;
      end
      if (wr_en_i && wr_first_i) begin
        rptr_q <= '0;
      end else if (rd_inc_i && !rd_last_o) begin
        rptr_q <= rptr_q + 1'b1;
      end
    end
  end

endmodule

// File: rtl/mbus_tx_sequencer.sv
// Buffers one outbound MBus message and replays it over the
// TX_REQ/TX_ACK handshake, then consumes the TX response.
module mbus_tx_sequencer
  import mbus_def::*;
#(
  parameter int          ADDR_WIDTH  = ADDR_WIDTH_DEF,
  parameter int          DATA_WIDTH  = DATA_WIDTH_DEF,
  parameter int          DEPTH       = DEPTH_DEF,
  parameter logic [15:0] ACK_TIMEOUT = ACK_TIMEOUT_DEF
) (
  input  logic                  CLK_EXT,
  input  logic                  RESET,
  input  logic [ADDR_WIDTH-1:0] IN_ADDR,
  input  logic                  IN_PRIORITY,
  input  logic [DATA_WIDTH-1:0] IN_DATA,
  input  logic                  IN_VALID,
  input  logic                  IN_LAST,
  output logic                  IN_READY,
  output logic [ADDR_WIDTH-1:0] TX_ADDR,
  output logic [DATA_WIDTH-1:0] TX_DATA,
  output logic                  TX_PEND,
  output logic                  TX_REQ,
  output logic                  TX_PRIORITY,
  input  logic                  TX_ACK,
  input  logic                  TX_SUCC,
  input  logic                  TX_FAIL,
  output logic                  TX_RESP_ACK,
  output logic                  BUSY,
  output logic                  DONE,
  output logic                  DONE_FAIL,
  output logic                  TRUNC
);

  localparam logic [15:0] TO_LAST = ACK_TIMEOUT - 16'd1;

  state_e                state_q;
  logic [ADDR_WIDTH-1:0] addr_q;
  logic [DATA_WIDTH-1:0] data_q;
  logic                  prio_q;
  logic                  pend_q;
  logic                  req_q;
  logic                  rack_q;
  logic                  done_q;
  logic                  dfail_q;
  logic                  trunc_q;
  logic                  fail_q;
  logic [15:0]           cnt_q;

  logic                  idle_fill;
  logic                  accept;
  logic                  timeout;
  logic                  rd_inc;
  logic [DATA_WIDTH-1:0] buf_data;
  logic                  buf_full;
  logic                  buf_last;

  assign idle_fill = (state_q == ST_IDLE) || (state_q == ST_FILL);
  assign IN_READY  = idle_fill && !RESET;
  assign BUSY      = !idle_fill;
  assign accept    = IN_VALID && IN_READY;
  assign timeout   = (cnt_q == TO_LAST);
  assign rd_inc    = (state_q == ST_RELEASE) && !TX_ACK;

  assign TX_ADDR     = addr_q;
  assign TX_DATA     = data_q;
  assign TX_PRIORITY = prio_q;
  assign TX_PEND     = pend_q;
  assign TX_REQ      = req_q;
  assign TX_RESP_ACK = rack_q;
  assign DONE        = done_q;
  assign DONE_FAIL   = dfail_q;
  assign TRUNC       = trunc_q;

  mbus_tx_word_buf #(
    .DATA_WIDTH (DATA_WIDTH),
    .DEPTH      (DEPTH)
  ) u_buf (
    .clk_i      (CLK_EXT),
    .rst_i      (RESET),
    .wr_en_i    (accept),
    .wr_first_i (state_q == ST_IDLE),
    .wr_data_i  (IN_DATA),
    .rd_inc_i   (rd_inc),
    .rd_data_o  (buf_data),
    .full_o     (buf_full),
    .rd_last_o  (buf_last)
  );

  always_ff @(posedge CLK_EXT) begin
    if (RESET) begin
      state_q <= ST_IDLE;
      addr_q  <= '0;
      data_q  <= '0;
      prio_q  <= 1'b0;
      pend_q  <= 1'b0;
      req_q   <= 1'b0;
      rack_q  <= 1'b0;
      done_q  <= 1'b0;
      dfail_q <= 1'b0;
      trunc_q <= 1'b0;
      fail_q  <= 1'b0;
      cnt_q   <= '0;
    end else begin
      done_q <= 1'b0;
      cnt_q  <= '0;
      unique case (state_q)
        ST_IDLE: begin
          if (accept) begin
            addr_q  <= IN_ADDR;
            prio_q  <= IN_PRIORITY;
            trunc_q <= 1'b0;
            state_q <= IN_LAST ? ST_SEND : ST_FILL;
          end
        end
        ST_FILL: begin
          if (accept && IN_LAST) begin
            state_q <= ST_SEND;
          end else if (accept && buf_full) begin
            trunc_q <= 1'b1;
            state_q <= ST_SEND;
          end
        end
        ST_SEND: begin
          data_q  <= buf_data;
          pend_q  <= !buf_last;
          req_q   <= 1'b1;
          state_q <= ST_REQ;
        end
        ST_REQ: begin
          if (TX_ACK) begin
            req_q   <= 1'b0;
            state_q <= ST_RELEASE;
          end else if (timeout) begin
            req_q   <= 1'b0;
            done_q  <= 1'b1;
            dfail_q <= 1'b1;
            state_q <= ST_IDLE;
          end else begin
            cnt_q <= cnt_q + 16'd1;
          end
        end
        ST_RELEASE: begin
          if (!TX_ACK) begin
            state_q <= buf_last ? ST_RESP : ST_SEND;
          end else if (timeout) begin
            // Abort now, but keep input stalled until the ack clears.
            done_q  <= 1'b1;
            dfail_q <= 1'b1;
            state_q <= ST_DRAIN;
          end else begin
            cnt_q <= cnt_q + 16'd1;
          end
        end
        ST_RESP: begin
          if (TX_SUCC || TX_FAIL) begin
            fail_q  <= TX_FAIL;
            rack_q  <= 1'b1;
            state_q <= ST_RESPACK;
          end else if (timeout) begin
            done_q  <= 1'b1;
            dfail_q <= 1'b1;
            state_q <= ST_IDLE;
          end else begin
            cnt_q <= cnt_q + 16'd1;
          end
        end
        ST_RESPACK: begin
          if (!TX_SUCC && !TX_FAIL) begin
            rack_q  <= 1'b0;
            done_q  <= 1'b1;
            dfail_q <= fail_q || trunc_q;
            state_q <= ST_IDLE;
          end
        end
        ST_DRAIN: begin
          if (!TX_ACK) begin
            state_q <= ST_IDLE;
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mbus_tx_sequencer.sv
// Scoreboard bench for mbus_tx_sequencer with a message-level
// reference model and a scripted TX-side responder.
module tb_mbus_tx_sequencer;

  typedef enum int {
    K_SUCC, K_FAIL, K_BOTH, K_RESPTO,
    K_NOACK, K_STUCK, K_RST
  } kind_e;

  typedef struct {
    logic [31:0] addr;
    logic        prio;
    logic [31:0] data;
    logic        pend;
    bit          to;
  } wexp_t;

  typedef struct {
    logic fail;
    logic trunc;
    logic busy;
  } dexp_t;

  typedef struct {
    kind_e kind;
    int    adly;
  } plan_t;

  localparam int DEPTH = 8;
  localparam int TO    = 16;

  logic        CLK_EXT;
  logic        RESET;
  logic [31:0] IN_ADDR;
  logic        IN_PRIORITY;
  logic [31:0] IN_DATA;
  logic        IN_VALID;
  logic        IN_LAST;
  logic        IN_READY;
  logic [31:0] TX_ADDR;
  logic [31:0] TX_DATA;
  logic        TX_PEND;
  logic        TX_REQ;
  logic        TX_PRIORITY;
  logic        TX_ACK;
  logic        TX_SUCC;
  logic        TX_FAIL;
  logic        TX_RESP_ACK;
  logic        BUSY;
  logic        DONE;
  logic        DONE_FAIL;
  logic        TRUNC;

  mbus_tx_sequencer #(
    .ADDR_WIDTH  (32),
    .DATA_WIDTH  (32),
    .DEPTH       (DEPTH),
    .ACK_TIMEOUT (16'(TO))
  ) dut (
    .CLK_EXT     (CLK_EXT),
    .RESET       (RESET),
    .IN_ADDR     (IN_ADDR),
    .IN_PRIORITY (IN_PRIORITY),
    .IN_DATA     (IN_DATA),
    .IN_VALID    (IN_VALID),
    .IN_LAST     (IN_LAST),
    .IN_READY    (IN_READY),
    .TX_ADDR     (TX_ADDR),
    .TX_DATA     (TX_DATA),
    .TX_PEND     (TX_PEND),
    .TX_REQ      (TX_REQ),
    .TX_PRIORITY (TX_PRIORITY),
    .TX_ACK      (TX_ACK),
    .TX_SUCC     (TX_SUCC),
    .TX_FAIL     (TX_FAIL),
    .TX_RESP_ACK (TX_RESP_ACK),
    .BUSY        (BUSY),
    .DONE        (DONE),
    .DONE_FAIL   (DONE_FAIL),
    .TRUNC       (TRUNC)
  );

  wexp_t wq[$];
  dexp_t dq[$];
  plan_t pq[$];

  int nvec = 0;
  int nerr = 0;
  bit have_plan = 0;
  bit rst_seen = 0;

  initial CLK_EXT = 1'b0;
  always #5 CLK_EXT = ~CLK_EXT;

  task automatic chk(input string nm,
                     input logic [63:0] act,
                     input logic [63:0] exp);
    nvec++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %0h want %0h @%0t",
               nm, act, exp, $time);
    end
  endtask

  task automatic bound_fail(input string nm);
    nvec++;
    nerr++;
    $display("FAIL %s: wait bound expired @%0t", nm, $time);
  endtask

  // Reference model: split the word stream into messages,
  // then predict what the TX side sees for each one.
  task automatic send_msg(input int n, input kind_e k,
                          input logic [31:0] a0,
                          input logic [31:0] base,
                          input bit seq, input int adly);
    logic [31:0] d[$];
    logic [31:0] a[$];
    logic        p[$];
    logic        l[$];
    int          st;
    int          cnt;
    int          len;
    int          nexp;
    bit          tr;
    for (int i = 0; i < n; i++) begin
      d.push_back(seq ? base + 32'(i) : $urandom);
      a.push_back(i == 0 ? a0 : $urandom);
      p.push_back(1'($urandom_range(0, 1)));
      l.push_back(i == n - 1);
    end
    st = 0;
    cnt = 0;
    for (int i = 0; i < n; i++) begin
      cnt++;
      if (l[i] || cnt == DEPTH) begin
        len = i - st + 1;
        tr = !l[i];
        if (k == K_NOACK || k == K_STUCK) nexp = 1;
        else if (k == K_RST) nexp = 2;
        else nexp = len;
        for (int j = 0; j < nexp; j++) begin
          wq.push_back('{a[st], p[st], d[st + j],
                         j != len - 1, k == K_NOACK});
        end
        if (k != K_RST) begin
          dq.push_back('{tr || k != K_SUCC, tr,
                         k == K_STUCK});
        end
        pq.push_back('{k, adly});
        st = i + 1;
        cnt = 0;
      end
    end
    for (int i = 0; i < n; i++) begin
      int t = 0;
      IN_VALID = 1'b1;
      IN_DATA = d[i];
      IN_ADDR = a[i];
      IN_PRIORITY = p[i];
      IN_LAST = l[i];
      while (!IN_READY && t < 3000) begin
        @(negedge CLK_EXT);
        t++;
      end
      if (t >= 3000) begin
        bound_fail("in_ready_wait");
        break;
      end
      @(negedge CLK_EXT);
    end
    IN_VALID = 1'b0;
    IN_LAST = 1'b0;
  endtask

  task automatic quiesce();
    int t = 0;
    while (t < 3000 && (wq.size() != 0 || dq.size() != 0 ||
           BUSY || have_plan || TX_RESP_ACK || TX_ACK)) begin
      @(negedge CLK_EXT);
      t++;
    end
    if (t >= 3000) begin
      bound_fail("quiesce");
      wq.delete();
      dq.delete();
    end
    repeat (2) @(negedge CLK_EXT);
  endtask

  // TX-side responder: drives only on negedges.
  initial begin
    plan_t pl;
    int    wi;
    logic  pend;
    TX_ACK = 1'b0;
    TX_SUCC = 1'b0;
    TX_FAIL = 1'b0;
    pl = '{K_SUCC, 0};
    wi = 0;
    forever begin
      @(negedge CLK_EXT);
      if (!TX_REQ || RESET) continue;
      if (!have_plan) begin
        if (pq.size() == 0) begin
          bound_fail("no_plan_for_req");
          do @(negedge CLK_EXT); while (TX_REQ);
          continue;
        end
        pl = pq.pop_front();
        have_plan = 1;
        wi = 0;
      end
      pend = TX_PEND;
      wi++;
      if (pl.kind == K_NOACK) begin
        do @(negedge CLK_EXT); while (TX_REQ);
        have_plan = 0;
        continue;
      end
      if (pl.kind == K_RST && wi == 2) begin
        rst_seen = 1;
        do @(negedge CLK_EXT); while (TX_REQ);
        rst_seen = 0;
        have_plan = 0;
        continue;
      end
      repeat (pl.adly) @(negedge CLK_EXT);
      TX_ACK = 1'b1;
      do @(negedge CLK_EXT); while (TX_REQ);
      if (pl.kind == K_STUCK) begin
        repeat (TO + 4) @(negedge CLK_EXT);
        TX_ACK = 1'b0;
        have_plan = 0;
        continue;
      end
      TX_ACK = 1'b0;
      if (pend) continue;
      if (pl.kind == K_RESPTO) begin
        have_plan = 0;
        continue;
      end
      repeat ($urandom_range(0, 2)) @(negedge CLK_EXT);
      TX_SUCC = (pl.kind == K_SUCC || pl.kind == K_BOTH);
      TX_FAIL = (pl.kind == K_FAIL || pl.kind == K_BOTH);
      do @(negedge CLK_EXT); while (!TX_RESP_ACK);
      repeat ($urandom_range(0, 3)) @(negedge CLK_EXT);
      TX_SUCC = 1'b0;
      TX_FAIL = 1'b0;
      have_plan = 0;
    end
  end

  // Monitor: samples 1 time unit after each active edge.
  initial begin
    wexp_t       cur;
    logic        prev_req;
    logic        prev_rack;
    logic [31:0] prev_data;
    int          req_len;
    cur = '{32'h0, 1'b0, 32'h0, 1'b0, 1'b0};
    prev_req = 1'b0;
    prev_rack = 1'b0;
    prev_data = '0;
    req_len = 0;
    forever begin
      @(posedge CLK_EXT);
      #1;
      if (RESET) begin
        prev_req = 1'b0;
        prev_rack = 1'b0;
        continue;
      end
      if (BUSY) chk("ready_while_busy", IN_READY, 0);
      if (TX_REQ && !prev_req) begin
        if (wq.size() == 0) begin
          bound_fail("unexpected_req");
          cur.to = 1'b0;
        end else begin
          cur = wq.pop_front();
          chk("tx_data", TX_DATA, cur.data);
          chk("tx_pend", TX_PEND, cur.pend);
          chk("tx_addr", TX_ADDR, cur.addr);
          chk("tx_prio", TX_PRIORITY, cur.prio);
          chk("ack_low_at_req", TX_ACK, 0);
        end
        req_len = 1;
      end else if (TX_REQ && prev_req) begin
        chk("tx_data_stable", TX_DATA, prev_data);
        req_len++;
      end else if (!TX_REQ && prev_req && cur.to) begin
        chk("req_timeout_len", req_len, TO);
      end
      if (prev_rack && !TX_RESP_ACK) begin
        chk("rack_drop_resp", TX_SUCC | TX_FAIL, 0);
      end
      if (DONE) begin
        if (dq.size() == 0) begin
          bound_fail("unexpected_done");
        end else begin
          dexp_t de;
          de = dq.pop_front();
          chk("done_fail", DONE_FAIL, de.fail);
          chk("trunc", TRUNC, de.trunc);
          chk("busy_at_done", BUSY, de.busy);
        end
      end
      prev_req = TX_REQ;
      prev_rack = TX_RESP_ACK;
      prev_data = TX_DATA;
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    int   t;
    int   n;
    int   r;
    kind_e k;
    RESET = 1'b1;
    IN_ADDR = '0;
    IN_PRIORITY = 1'b0;
    IN_DATA = '0;
    IN_VALID = 1'b0;
    IN_LAST = 1'b0;
    repeat (3) @(negedge CLK_EXT);
    chk("rst_tx_req", TX_REQ, 0);
    chk("rst_rack", TX_RESP_ACK, 0);
    chk("rst_busy", BUSY, 0);
    chk("rst_done", DONE, 0);
    chk("rst_done_fail", DONE_FAIL, 0);
    chk("rst_trunc", TRUNC, 0);
    chk("rst_pend", TX_PEND, 0);
    chk("rst_data", TX_DATA, 0);
    chk("rst_addr", TX_ADDR, 0);
    chk("rst_prio", TX_PRIORITY, 0);
    chk("rst_in_ready", IN_READY, 0);
    RESET = 1'b0;
    #1;
    chk("idle_in_ready", IN_READY, 1);

    send_msg(1, K_SUCC, 32'h0000_0051, 32'hDEADBEEF, 1, 3);
    quiesce();
    send_msg(4, K_SUCC, 32'h1234_5678, 32'd1, 1, 1);
    quiesce();
    send_msg(10, K_SUCC, 32'hA5A5_0001, 32'h100, 1, 0);
    quiesce();
    send_msg(1, K_NOACK, 32'h77, 32'h55, 1, 0);
    quiesce();
    send_msg(2, K_BOTH, 32'h88, 32'h66, 1, 2);
    quiesce();

    send_msg(3, K_RST, 32'h99, 32'h200, 1, 1);
    t = 0;
    while (!rst_seen && t < 500) begin
      @(negedge CLK_EXT);
      t++;
    end
    if (t >= 500) bound_fail("rst_trigger");
    RESET = 1'b1;
    @(posedge CLK_EXT);
    #1;
    chk("mid_rst_req", TX_REQ, 0);
    chk("mid_rst_busy", BUSY, 0);
    chk("mid_rst_done", DONE, 0);
    chk("mid_rst_rack", TX_RESP_ACK, 0);
    @(negedge CLK_EXT);
    RESET = 1'b0;
    quiesce();
    send_msg(1, K_SUCC, 32'h0000_0042, 32'hCAFE, 1, 1);
    quiesce();

    send_msg(3, K_STUCK, 32'h11, 32'h300, 1, 0);
    quiesce();
    send_msg(2, K_RESPTO, 32'h22, 32'h400, 1, 1);
    quiesce();
    send_msg(5, K_FAIL, 32'h33, 32'h500, 1, 2);
    quiesce();
    send_msg(8, K_SUCC, 32'h44, 32'h600, 1, 0);
    quiesce();

    for (int i = 0; i < 30; i++) begin
      n = $urandom_range(1, 10);
      r = $urandom_range(0, 9);
      if (r < 5) k = K_SUCC;
      else if (r == 5) k = K_FAIL;
      else if (r == 6) k = K_BOTH;
      else if (r == 7) k = K_RESPTO;
      else if (r == 8) k = K_NOACK;
      else k = K_STUCK;
      send_msg(n, k, $urandom, 32'h0, 0,
               $urandom_range(0, 3));
      quiesce();
    end

    $display("== %0d vectors applied, %0d miscompares ==",
             nvec, nerr);
    $finish;
  end

endmodule
